// File: rtl/elevator_pkg.sv
// Shared state encoding, drive-output bundle and width helper for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE_UP   = 3'd1,
    S_MOVE_DOWN = 3'd2,
    S_DOOR_OPEN = 3'd3,
    S_CLOSE     = 3'd4
  } state_t;

  typedef struct packed {
    logic open;
    logic close;
    logic go_up;
    logic go_down;
  } drive_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int floor_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic drive_t drive_of(input state_t s);
    drive_t d;
    d = '0;
    case (s)
      S_MOVE_UP:   d.go_up   = 1'b1;
      S_MOVE_DOWN: d.go_down = 1'b1;
      S_DOOR_OPEN: d.open    = 1'b1;
      S_CLOSE:     d.close   = 1'b1;
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Button inputs and motor/door drive outputs between the panel side (master) and the scheduler (slave).
interface elevator_scheduler_if #(
  parameter int N_FLOORS = 10
);
  import elevator_pkg::*;
  localparam int FW = floor_width(N_FLOORS);

  logic [N_FLOORS-1:0] button_up;
  logic [N_FLOORS-1:0] button_down;
  logic [N_FLOORS-1:0] button_floor;
  logic                open;
  logic                close;
  logic                go_up;
  logic                go_down;
  logic [FW-1:0]       floor_number;
  logic                dir_up;

  modport master (
    output button_up, button_down, button_floor,
    input  open, close, go_up, go_down, floor_number, dir_up
  );

  modport slave (
    input  button_up, button_down, button_floor,
    output open, close, go_up, go_down, floor_number, dir_up
  );

endinterface

// File: rtl/elevator_req_bank.sv
// Pending hall/car request registers with door-time clearing, plus the above/below/here
// reductions and next-floor stop decisions relative to the current floor.
module elevator_req_bank import elevator_pkg::*; #(
  parameter int N_FLOORS = 10,
  parameter int FW       = floor_width(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] i_btn_up,
  input  logic [N_FLOORS-1:0] i_btn_dn,
  input  logic [N_FLOORS-1:0] i_btn_car,
  input  logic [FW-1:0]       i_floor,
  input  logic                i_dir_up,
  input  logic                i_door_open,
  output logic                o_here,
  output logic                o_above,
  output logic                o_below,
  output logic                o_stop_up,
  output logic                o_stop_dn,
  output logic                o_reopen
);

  localparam logic [N_FLOORS-1:0] TOP_BIT = {1'b1, {(N_FLOORS-1){1'b0}}};
  localparam logic [N_FLOORS-1:0] BOT_BIT = {{(N_FLOORS-1){1'b0}}, 1'b1};

  logic [N_FLOORS-1:0] r_up, r_dn, r_car;
  logic [N_FLOORS-1:0] w_btn_up, w_btn_dn, w_any, w_sel;
  logic [N_FLOORS-1:0] w_clr_up, w_clr_dn, w_clr_car;
  logic w_above, w_below, w_ahead_up, w_ahead_dn, w_hit_up, w_hit_dn;
  logic w_here_car, w_here_up, w_here_dn, w_press_car, w_press_up, w_press_dn;
  logic w_up_ok, w_dn_ok;
  int   w_f;

  assign w_btn_up = i_btn_up & ~TOP_BIT;
  assign w_btn_dn = i_btn_dn & ~BOT_BIT;
  assign w_any    = r_up | r_dn | r_car;
  assign w_f      = int'(i_floor);

  always_comb begin
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_ahead_up  = 1'b0;
    w_ahead_dn  = 1'b0;
    w_hit_up    = 1'b0;
    w_hit_dn    = 1'b0;
    w_here_car  = 1'b0;
    w_here_up   = 1'b0;
    w_here_dn   = 1'b0;
    w_press_car = 1'b0;
    w_press_up  = 1'b0;
    w_press_dn  = 1'b0;
    w_sel       = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > w_f)     w_above    = w_above    | w_any[i];
      if (i < w_f)     w_below    = w_below    | w_any[i];
      if (i > w_f + 1) w_ahead_up = w_ahead_up | w_any[i];
      if (i < w_f - 1) w_ahead_dn = w_ahead_dn | w_any[i];
      if (i == w_f + 1) w_hit_up = r_car[i] | r_up[i];
      if (i == w_f - 1) w_hit_dn = r_car[i] | r_dn[i];
      if (i == w_f) begin
        w_sel[i]    = 1'b1;
        w_here_car  = r_car[i];
        w_here_up   = r_up[i];
        w_here_dn   = r_dn[i];
        w_press_car = i_btn_car[i];
        w_press_up  = w_btn_up[i];
        w_press_dn  = w_btn_dn[i];
      end
    end
  end

  assign w_up_ok = i_dir_up | ~w_above;
  assign w_dn_ok = ~i_dir_up | ~w_below;

  // Only calls the door would actually clear count as "here", so IDLE never
  // reopens the door for a hall call it is deliberately keeping for later.
  assign o_here    = w_here_car | (w_here_up & w_up_ok) | (w_here_dn & w_dn_ok);
  assign o_above   = w_above;
  assign o_below   = w_below;
  assign o_stop_up = w_hit_up | ~w_ahead_up;
  assign o_stop_dn = w_hit_dn | ~w_ahead_dn;
  assign o_reopen  = i_door_open &
                     (w_press_car | (w_press_up & w_up_ok) | (w_press_dn & w_dn_ok));

  assign w_clr_car = i_door_open ? w_sel : '0;
  assign w_clr_up  = w_clr_car & {N_FLOORS{w_up_ok}};
  assign w_clr_dn  = w_clr_car & {N_FLOORS{w_dn_ok}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up  <= '0;
      r_dn  <= '0;
      r_car <= '0;
    end else begin
      r_up  <= (r_up  | w_btn_up)  & ~w_clr_up;
      r_dn  <= (r_dn  | w_btn_dn)  & ~w_clr_dn;
      r_car <= (r_car | i_btn_car) & ~w_clr_car;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator controller: FSM, travel and door-dwell counters, registered drives.
module elevator_scheduler import elevator_pkg::*; #(
  parameter int N_FLOORS      = 10,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  elevator_scheduler_if.slave bus
);

  localparam int FW = floor_width(N_FLOORS);
  localparam int TW = floor_width(TRAVEL_CYCLES);
  localparam int DW = floor_width(DOOR_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  state_t        r_state;
  drive_t        r_drv;
  logic [FW-1:0] r_floor;
  logic          r_dir_up;
  logic [TW-1:0] r_tcnt;
  logic [DW-1:0] r_dcnt;

  logic w_here, w_above, w_below, w_stop_up, w_stop_dn, w_reopen;

  elevator_req_bank #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_req_bank (
    .clk         (clk),
    .rst         (rst_n),
    .i_btn_up    (bus.button_up),
    .i_btn_dn    (bus.button_down),
    .i_btn_car   (bus.button_floor),
    .i_floor     (r_floor),
    .i_dir_up    (r_dir_up),
    .i_door_open (r_state == S_DOOR_OPEN),
    .o_here      (w_here),
    .o_above     (w_above),
    .o_below     (w_below),
    .o_stop_up   (w_stop_up),
    .o_stop_dn   (w_stop_dn),
    .o_reopen    (w_reopen)
  );

  // Drives are loaded together with the state so they are pure register outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_drv    <= '0;
      r_floor  <= '0;
      r_dir_up <= 1'b0;
      r_tcnt   <= '0;
      r_dcnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_here) begin
            r_state <= S_DOOR_OPEN;
            r_drv   <= drive_of(S_DOOR_OPEN);
            r_dcnt  <= '0;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state  <= S_MOVE_UP;
            r_drv    <= drive_of(S_MOVE_UP);
            r_dir_up <= 1'b1;
            r_tcnt   <= '0;
          end else if (w_below) begin
            r_state  <= S_MOVE_DOWN;
            r_drv    <= drive_of(S_MOVE_DOWN);
            r_dir_up <= 1'b0;
            r_tcnt   <= '0;
          end
        end
        S_MOVE_UP: begin
          if (r_tcnt == T_LAST) begin
            r_tcnt  <= '0;
            r_floor <= r_floor + 1'b1;
            if (w_stop_up) begin
              r_state <= S_DOOR_OPEN;
              r_drv   <= drive_of(S_DOOR_OPEN);
              r_dcnt  <= '0;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_MOVE_DOWN: begin
          if (r_tcnt == T_LAST) begin
            r_tcnt  <= '0;
            r_floor <= r_floor - 1'b1;
            if (w_stop_dn) begin
              r_state <= S_DOOR_OPEN;
              r_drv   <= drive_of(S_DOOR_OPEN);
              r_dcnt  <= '0;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_DOOR_OPEN: begin
          if (w_reopen) begin
            r_dcnt <= '0;
          end else if (r_dcnt == D_LAST) begin
            r_dcnt  <= '0;
            r_state <= S_CLOSE;
            r_drv   <= drive_of(S_CLOSE);
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_CLOSE: begin
          r_state <= S_IDLE;
          r_drv   <= drive_of(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_drv   <= '0;
        end
      endcase
    end
  end

  assign bus.open         = r_drv.open;
  assign bus.close        = r_drv.close;
  assign bus.go_up        = r_drv.go_up;
  assign bus.go_down      = r_drv.go_down;
  assign bus.floor_number = r_floor;
  assign bus.dir_up       = r_dir_up;

  a_drive_excl: assert property (@(posedge clk) disable iff (rst_n)
    $onehot0({r_drv.open, r_drv.go_up, r_drv.go_down}));

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Control FSM and request scheduler for a single-car elevator serving N_FLOORS floors.
- Latches hall calls (up/down) and car calls into a pending-request bank.
- Tracks the current floor and runs a collective (SCAN) policy: keep direction while requests remain ahead, otherwise reverse.
- Sequences door open/close using travel and door-dwell counters.
- Sits between the button inputs and the motor/door drive outputs; replaces the bare control stub in the elevator top level.

Parameters:
N_FLOORS, 10, number of floors (>= 2); floor 0 is the bottom floor.
TRAVEL_CYCLES, 16, clock cycles to move one floor (>= 1).
DOOR_CYCLES, 8, clock cycles the door stays open (>= 1).
FW, $clog2(N_FLOORS), floor-number width (derived; not overridden).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active-high (1 = reset); the port name follows the codebase, the polarity is fixed high.
button_up  input  N_FLOORS  hall up-call, bit f = floor f; level-sampled every cycle; bit N_FLOORS-1 ignored.
button_down  input  N_FLOORS  hall down-call, bit f = floor f; level-sampled; bit 0 ignored.
button_floor  input  N_FLOORS  car call, bit f = floor f; level-sampled.
open  output  1  door-open drive; high for the whole DOOR_OPEN state.
close  output  1  door-close drive; high for exactly one cycle (CLOSE state).
go_up  output  1  motor up; high in MOVE_UP.
go_down  output  1  motor down; high in MOVE_DOWN.
floor_number  output  FW  current floor, 0..N_FLOORS-1.
dir_up  output  1  committed direction: 1 = up, 0 = down/idle.

Behaviour:
Reset (async, asserted = 1):
- State IDLE; floor_number = 0; dir_up = 0.
- All request bits cleared; both counters 0; all drive outputs 0.
- Reset mid-travel or with the door open aborts immediately; pending requests are lost.

Request bank (req_up, req_dn, req_car):
- Each bit is set the cycle after its button bit is sampled high (OR-in), and held until serviced.
- Derived terms: above = any request bit at floor > current; below = any at floor < current; here = any at the current floor.

States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, CLOSE.
- IDLE:
  - If here: go to DOOR_OPEN.
  - Else if above and (dir_up or !below): go to MOVE_UP, set dir_up = 1.
  - Else if below: go to MOVE_DOWN, set dir_up = 0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - The travel counter counts 0..TRAVEL_CYCLES-1; at the terminal count floor_number increments or decrements and the counter reloads.
  - At each new floor f, stop (go to DOOR_OPEN) when any of these hold: req_car[f]; the hall request in the direction of travel at f; no further requests ahead.
  - Otherwise continue.
  - Motion never leaves the range 0..N_FLOORS-1; the top and bottom floors always stop.
- DOOR_OPEN:
  - open = 1 while the door counter runs 0..DOOR_CYCLES-1, then go to CLOSE.
  - On entry to floor f, clear req_car[f].
  - Clear req_up[f] if dir_up, or if there is no request above.
  - Clear req_dn[f] if !dir_up, or if there is no request below.
  - A new matching press at f during DOOR_OPEN is not latched and restarts the door counter (reopen behaviour).
- CLOSE: close = 1 for one cycle, then go to IDLE, which re-evaluates.

Timing and priority:
- Press at edge t: request visible at t+1; FSM leaves IDLE at t+2.
- Simultaneous set and clear of the same bit: clear wins only in DOOR_OPEN at the current floor; otherwise set wins.

Output rules:
- go_up, go_down and open are mutually exclusive; this is checked by assertion.
- All outputs are registered or decoded from state only, never from inputs.

Decomposition:
- Package elevator_pkg: state encodings (S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN, S_CLOSE) and the shared floor-width function.
- Sub-module elevator_req_bank: the three request registers, the set/clear logic, and the above/below/here reductions relative to floor_number.
- The FSM and both counters stay in elevator_scheduler.

Test Plan:
Sim values for all scenarios: N_FLOORS=10, TRAVEL_CYCLES=3, DOOR_CYCLES=4.
1. Reset, then a 1-cycle pulse on button_floor[3] -> go_up high 9 consecutive cycles; floor_number steps 1, 2, 3 every 3 cycles; open high 4 cycles; close high 1 cycle; back to IDLE with floor_number = 3.
2. At floor 0, button_floor[6] then button_up[2] pressed while passing floor 1 -> stop at 2 (open 4 cycles, req_up[2] cleared), resume up, stop at 6.
3. At floor 5, moving up to car call 8 with button_down[3] pending -> serve 8 first, then reverse (dir_up = 0) and serve 3; the down call at 3 is cleared on arrival.
4. Idle at floor 4, button_up[4] pressed -> DOOR_OPEN within 2 cycles, no motion; re-press during the 3rd open cycle -> open extends to 4 cycles from the re-press.
5. button_up[9] and button_down[0] pressed alone -> ignored, FSM stays IDLE; button_floor[9] from floor 0 -> stops at 9 and never exceeds it.
6. Assert rst_n mid-travel between floors 2 and 3 -> all outputs 0 the same cycle, floor_number = 0, requests empty after release.
